// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: four-channel round-robin arbiter driving the address1/address0
// select pair of a 4:1 data mux, with a valid/ready handshake and a transfer counter.
// Optional feature: define MUX_ARB_LOCK_EN to keep re-granting the current holder
// on each transfer for as long as it keeps requesting (burst lock).
module mux_select_arbiter #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic                   ready,
  output logic                   valid,
  output logic [3:0]             grant,
  output logic                   address0,
  output logic                   address1,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                 r_state, w_state_d;
  logic [1:0]             r_last, w_last_d;
  logic [1:0]             r_addr, w_addr_d;
  logic [3:0]             r_grant, w_grant_d;
  logic [COUNT_WIDTH-1:0] r_count, w_count_d;

  logic       w_xfer;
  logic [1:0] w_base;
  logic [1:0] w_win;
  logic       w_found;

  // Round-robin search starting after the pointer; on a transfer the pointer used is
  // the index just completed so back-to-back grants rotate with no bubble.
  always_comb begin
    w_xfer  = (r_state == StGrant) && ready;
    w_base  = w_xfer ? r_addr : r_last;
    w_win   = w_base;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && req[w_base + 2'(i)]) begin
        w_found = 1'b1;
        w_win   = w_base + 2'(i);
      end
    end
`ifdef MUX_ARB_LOCK_EN
    // Holder keeps the grant while it still requests.
    if (w_xfer && req[r_addr]) begin
      w_win = r_addr;
    end
`else
`endif
  end

  // Next-state logic: hold everything by default, address holds through IDLE.
  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    w_addr_d  = r_addr;
    w_grant_d = r_grant;
    w_count_d = r_count;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d = StGrant;
          w_addr_d  = w_win;
          w_grant_d = 4'b0001 << w_win;
        end
      end
      StGrant: begin
        if (w_xfer) begin
          w_last_d  = r_addr;
          w_count_d = r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          if (w_found) begin
            w_addr_d  = w_win;
            w_grant_d = 4'b0001 << w_win;
          end else begin
            w_state_d = StIdle;
            w_grant_d = 4'b0000;
          end
        end else if (!req[r_addr]) begin
          // Holder withdrew before being served.
          w_state_d = StIdle;
          w_grant_d = 4'b0000;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = 4'b0000;
      end
    endcase
  end

  // State registers; reset points the pointer at channel 3 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_last  <= 2'd3;
      r_addr  <= 2'd0;
      r_grant <= 4'b0000;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
      r_addr  <= w_addr_d;
      r_grant <= w_grant_d;
      r_count <= w_count_d;
    end
  end

  assign valid      = (r_state == StGrant);
  assign grant      = r_grant;
  assign address1   = r_addr[1];
  assign address0   = r_addr[0];
  assign xfer_count = r_count;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed self-checking bench for mux_select_arbiter. Observed outputs are packed as
// {valid, address1, address0, grant[3:0], xfer_count[7:0]} and sampled 1 time unit
// after each rising edge; inputs are changed at the same point.
module tb_mux_select_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       ready;
  logic       valid;
  logic [3:0] grant;
  logic       address0;
  logic       address1;
  logic [7:0] xfer_count;

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] obs;
  logic [14:0] exp_v;

  mux_select_arbiter #(.COUNT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ready      (ready),
    .valid      (valid),
    .grant      (grant),
    .address0   (address0),
    .address1   (address1),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    obs = {valid, address1, address0, grant, xfer_count};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = {1'b0, 2'b00, 4'b0000, 8'd0};
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, exp_v);
      end
      n_vec++;
    end
    reset = 1'b0;
    step();
    exp_v = {1'b1, 2'b00, 4'b0001, 8'd0};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", obs, exp_v);
    end
    n_vec++;
  endtask

  task automatic test_full_load();
    logic [1:0] idx;
    do_reset();
    req   = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
`ifdef MUX_ARB_LOCK_EN
      idx = 2'd0;
`else
      idx = 2'(i);
`endif
      exp_v = {1'b1, idx, 4'b0001 << idx, 8'(i)};
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL full_load[%0d]: got %h want %h", i, obs, exp_v);
      end
      n_vec++;
    end
    step();
    if (obs[7:0] !== 8'd5 || obs[14] !== 1'b1) begin
      n_err++;
      $display("FAIL full_load_count: got %h want count 05 valid 1", obs);
    end
    n_vec++;
    req   = 4'b0000;
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req   = 4'b0100;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {1'b1, 2'b10, 4'b0100, 8'd0};
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got %h want %h", i, obs, exp_v);
      end
      n_vec++;
    end
    // Fourth granted cycle carries ready=1 while the request is dropped.
    ready = 1'b1;
    req   = 4'b0000;
    step();
    exp_v = {1'b0, 2'b10, 4'b0000, 8'd1};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL backpressure_xfer: got %h want %h", obs, exp_v);
    end
    n_vec++;
    step();
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL backpressure_idle: got %h want %h", obs, exp_v);
    end
    n_vec++;
  endtask

  // Continues from test_backpressure: last=2, count=1.
  task automatic test_withdraw_reset();
    ready = 1'b0;
    req   = 4'b0010;
    step();
    exp_v = {1'b1, 2'b01, 4'b0010, 8'd1};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL withdraw_grant: got %h want %h", obs, exp_v);
    end
    n_vec++;
    req = 4'b0000;
    step();
    exp_v = {1'b0, 2'b01, 4'b0000, 8'd1};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL withdraw_drop: got %h want %h", obs, exp_v);
    end
    n_vec++;
    req = 4'b0010;
    step();
    exp_v = {1'b1, 2'b01, 4'b0010, 8'd1};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL withdraw_regrant: got %h want %h", obs, exp_v);
    end
    n_vec++;
    // Reset coincides with a would-be transfer.
    reset = 1'b1;
    ready = 1'b1;
    step();
    exp_v = {1'b0, 2'b00, 4'b0000, 8'd0};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL midgrant_reset: got %h want %h", obs, exp_v);
    end
    n_vec++;
    reset = 1'b0;
    req   = 4'b0000;
    ready = 1'b0;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    req   = 4'b0001;
    ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step();
    end
    exp_v = {1'b1, 2'b00, 4'b0001, 8'd255};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL wrap_255: got %h want %h", obs, exp_v);
    end
    n_vec++;
    step();
    exp_v = {1'b1, 2'b00, 4'b0001, 8'd0};
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL wrap_0: got %h want %h", obs, exp_v);
    end
    n_vec++;
    req   = 4'b0000;
    ready = 1'b0;
  endtask

  task automatic test_lock();
    logic [1:0] idx;
    do_reset();
    req   = 4'b0011;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef MUX_ARB_LOCK_EN
      idx = 2'd0;
`else
      idx = 2'(i % 2);
`endif
      exp_v = {1'b1, idx, 4'b0001 << idx, 8'(i)};
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL lock[%0d]: got %h want %h", i, obs, exp_v);
      end
      n_vec++;
    end
    req   = 4'b0000;
    ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_withdraw_reset();
    test_counter_wrap();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_select_arbiter.md
# mux_select_arbiter

Four-channel round-robin arbiter that generates the `address1`/`address0` select pair for the 4:1 data multiplexer stage. It sits directly upstream of that multiplexer. It takes one request line per mux input and grants one channel at a time. While a grant is active, it holds the select lines stable until the downstream consumer accepts the selected data with a valid/ready handshake. It also counts completed transfers for debug and test.

## Interface
Parameters:
- `COUNT_WIDTH`, default 8: width of the transfer counter.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  4  per-channel request; `req[i]` corresponds to mux input `in_i`.
- `ready`  input  1  downstream accepts the mux output this cycle.
- `valid`  output  1  mux output is a granted channel's data.
- `grant`  output  4  one-hot grant; all zeros when `valid`=0.
- `address0`  output  1  mux select bit 0 (LSB of granted index).
- `address1`  output  1  mux select bit 1 (MSB of granted index).
- `xfer_count`  output  COUNT_WIDTH  number of completed transfers, modulo 2^COUNT_WIDTH.

## Operation
- State machine with two states, IDLE and GRANT. There is an internal 2-bit `last` pointer, which is the index of the most recently completed transfer.
- Arbitration order from a given `last`: `last+1`, `last+2`, `last+3`, `last`, all mod 4. The first channel in that order with `req` high wins.
- IDLE:
  - `valid`=0 and `grant`=0.
  - `address1`/`address0` hold their previous value.
  - If any `req` bit is high, register the winner into address/grant and go to GRANT.
- GRANT:
  - `valid`=1. `grant` is one-hot for the granted index {`address1`,`address0`}.
  - Address and grant must not change until the state exits GRANT.
- Transfer occurs when `valid`=1 and `ready`=1 at a rising edge. On a transfer:
  - `last` takes the granted index.
  - `xfer_count` increments, wrapping from all-ones to 0.
  - Arbitration is then re-run in the same edge using the current `req` and the new `last`.
  - If there is a winner, stay in GRANT with the new index, so back-to-back transfers have no bubble.
  - If there is no winner, go to IDLE.
- Withdrawal: in GRANT, if `req` for the granted channel is low and no transfer occurs, go to IDLE.
  - `last` and `xfer_count` are unchanged.
  - A transfer takes precedence when the withdrawal and `ready` coincide.
- Requests on non-granted channels never preempt the current grant.
- Reset, including mid-transfer, at the edge:
  - State goes to IDLE and `last` goes to 3, so channel 0 has first priority.
  - `valid`=0, `grant`=0, `address1`=`address0`=0, `xfer_count`=0.
  - `reset` overrides any simultaneous transfer or request.

## Timing
- All outputs are registered; nothing combinational runs from `req` or `ready` to any output.
- Grant latency: `req` sampled high in IDLE at edge k gives `valid`/`grant`/address visible from edge k onward, i.e. one cycle after `req` rises.
- `xfer_count` reflects a transfer from the edge on which it completed.
- Sustained throughput is one transfer per cycle when requests are continuous and `ready`=1.
- Select lines settle with `valid`. The downstream mux output is valid in the same cycle, after mux propagation delay.

## Configuration
- `MUX_ARB_LOCK_EN` defined:
  - On a transfer, if `req` for the granted channel is still high, the same channel is re-granted. This gives burst lock.
  - `last` still updates.
  - Rotation happens only when the holder drops its request.
- `MUX_ARB_LOCK_EN` undefined: strict round-robin after every transfer, as described in Operation.

## Test plan
- Reset: assert `reset` for 2 cycles with `req`=4'b1111.
  - During reset: `valid`=0, `grant`=0, address=00, `xfer_count`=0.
  - First cycle after release: `grant`=4'b0001.
- Full load: `req`=4'b1111, `ready`=1 for 5 cycles.
  - `grant` sequence 0001, 0010, 0100, 1000, 0001.
  - {`address1`,`address0`} sequence 00, 01, 10, 11, 00.
  - `xfer_count` reaches 5, with no idle cycle.
- Backpressure: `req`=4'b0100, `ready`=0 for 3 cycles, then 1 for one cycle, then `req`=0.
  - Address is held at 10 and `grant`=0100 for all 4 cycles.
  - Exactly one transfer occurs, then IDLE.
- Withdrawal and reset mid-grant:
  - Grant channel 1, then drop `req[1]` with `ready`=0: `valid`=0 next cycle and `xfer_count` is unchanged.
  - Re-grant, then assert `reset`: all outputs are zero next cycle.
- Counter wrap: with `COUNT_WIDTH`=8, perform 256 transfers; `xfer_count` returns to 0.
- Lock: `req`=4'b0011, `ready`=1.
  - With `MUX_ARB_LOCK_EN` defined: `grant` stays at 0001 every cycle.
  - Without it: `grant` alternates 0001/0010.
